// File: rtl/scr1_memif_pkg.sv
// rtl/scr1_memif_pkg.sv - memory interface types and lane helpers
//   Contents: command/width/response enums, byte-enable generation,
//   read-lane extraction; shared by the imem and dmem controllers.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Byte write enables for an access of the given width at byte offset off.
    // The illegal width yields no enables.
    function automatic logic [3:0] scr1_be_gen(input logic [1:0] width,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << off;
            SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << off;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Pull the addressed lane out of a RAM word and right-align it,
    // zero-extending to the full data width.
    function automatic logic [31:0] scr1_rdata_align(input logic [1:0]  width,
                                                     input logic [1:0]  off,
                                                     input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (width)
            SCR1_MEM_WIDTH_BYTE:  res = {24'b0, sh[7:0]};
            SCR1_MEM_WIDTH_HWORD: res = {16'b0, sh[15:0]};
            SCR1_MEM_WIDTH_WORD:  res = rdata;
            default:              res = 32'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scr1_dp_memory_dmem_ctrl.sv
// rtl/scr1_dp_memory_dmem_ctrl.sv - dmem initiator for TCM dual-port RAM port B
//   Ports: clk, rst_n (async, active low);
//   dmem_req/cmd/width/addr/wdata -> dmem_req_ack, dmem_rdata, dmem_resp (core side);
//   mem_ren/wen/web/addr/wdata -> RAM port B, mem_rdata <- RAM registered qb.
//   One access per cycle, response one cycle after accept.
module scr1_dp_memory_dmem_ctrl
    import scr1_memif_pkg::*;
#(
    parameter int          SCR1_WIDTH = 32,
    parameter logic [31:0] SCR1_SIZE  = 32'h0001_0000,
    parameter logic [31:0] SCR1_BASE  = 32'h0048_0000,
    parameter int          SCR1_AW    = $clog2(SCR1_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dmem_req,
    input  logic               dmem_cmd,
    input  logic [1:0]         dmem_width,
    input  logic [31:0]        dmem_addr,
    input  logic [31:0]        dmem_wdata,
    output logic               dmem_req_ack,
    output logic [31:0]        dmem_rdata,
    output logic [1:0]         dmem_resp,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [3:0]         mem_web,
    output logic [SCR1_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    logic [31:0]         rel_addr;
    logic [1:0]          off;
    logic                misaligned;
    logic                outrange;
    logic                err;
    logic                drive;

    type_scr1_mem_resp_e resp_r;
    logic [1:0]          off_r;
    logic [1:0]          width_r;
    logic                cmd_r;

    // No backpressure: every request seen outside reset is taken.
    assign dmem_req_ack = rst_n;

    // Addresses below the base wrap to huge offsets and fail the range test.
    assign rel_addr   = dmem_addr - SCR1_BASE;
    assign off        = dmem_addr[1:0];
    assign outrange   = (rel_addr >= SCR1_SIZE);
    assign misaligned = ((dmem_width == SCR1_MEM_WIDTH_HWORD) && off[0])
                      || ((dmem_width == SCR1_MEM_WIDTH_WORD) && (off != 2'b00))
                      || (dmem_width == SCR1_MEM_WIDTH_ERROR);
    assign err        = misaligned | outrange;
    assign drive      = rst_n & dmem_req & ~err;

    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_web   = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        if (drive) begin
            mem_addr = rel_addr[SCR1_AW-1:0];
            if (dmem_cmd == SCR1_MEM_CMD_WR) begin
                mem_wen   = 1'b1;
                mem_web   = scr1_be_gen(dmem_width, off);
                mem_wdata = dmem_wdata << {off, 3'b000};
            end else begin
                mem_ren   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r  <= SCR1_MEM_RESP_NOTRDY;
            off_r   <= 2'b00;
            width_r <= 2'b00;
            cmd_r   <= 1'b0;
        end else begin
            if (dmem_req) begin
                resp_r <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            end else begin
                resp_r <= SCR1_MEM_RESP_NOTRDY;
            end
            off_r   <= off;
            width_r <= dmem_width;
            cmd_r   <= dmem_cmd;
        end
    end

    assign dmem_resp = resp_r;

    // mem_rdata is the RAM's registered output, so it lines up with resp_r.
    always_comb begin
        dmem_rdata = 32'b0;
        if (rst_n && (resp_r == SCR1_MEM_RESP_RDY_OK) && (cmd_r == SCR1_MEM_CMD_RD)) begin
            dmem_rdata = scr1_rdata_align(width_r, off_r, mem_rdata);
        end
    end

endmodule

// File: tb/tb_scr1_dp_memory_dmem_ctrl.sv
// tb/tb_scr1_dp_memory_dmem_ctrl.sv - directed bench for scr1_dp_memory_dmem_ctrl
module tb_scr1_dp_memory_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h0048_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;
    localparam int          AW   = 16;

    localparam logic       RD = 1'b0;
    localparam logic       WR = 1'b1;
    localparam logic [1:0] W_B = 2'd0;
    localparam logic [1:0] W_H = 2'd1;
    localparam logic [1:0] W_W = 2'd2;
    localparam logic [1:0] W_X = 2'd3;
    localparam logic [31:0] R_IDLE = 32'd0;
    localparam logic [31:0] R_OK   = 32'd1;
    localparam logic [31:0] R_ERR  = 32'd2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dmem_req;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_req_ack;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;
    logic          mem_ren;
    logic          mem_wen;
    logic [3:0]    mem_web;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scr1_dp_memory_dmem_ctrl #(
        .SCR1_WIDTH (32),
        .SCR1_SIZE  (SIZE),
        .SCR1_BASE  (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_web      (mem_web),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Port-B RAM: byte-enabled write, registered read, write visible next cycle.
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_web[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_ren) mem_rdata <= ram[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic cmd, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        dmem_req   = req;
        dmem_cmd   = cmd;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = d;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic no_strobe(input string tag);
        chk({tag, "_ren"}, {31'b0, mem_ren}, 32'd0);
        chk({tag, "_wen"}, {31'b0, mem_wen}, 32'd0);
        chk({tag, "_web"}, {28'b0, mem_web}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        mem_rdata = 32'h0;
        rst_n = 1'b0;

        // Reset with a request held
        drive(1'b1, RD, W_W, BASE, 32'h0);
        for (int i = 0; i < 3; i++) begin
            no_strobe("rst");
            chk("rst_resp", {30'b0, dmem_resp}, R_IDLE);
            chk("rst_rdata", dmem_rdata, 32'h0);
            tick();
        end
        rst_n = 1'b1;
        drive(1'b1, RD, W_W, BASE, 32'h0);
        chk("post_rst_resp", {30'b0, dmem_resp}, R_IDLE);
        chk("post_rst_ack", {31'b0, dmem_req_ack}, 32'd1);
        chk("post_rst_ren", {31'b0, mem_ren}, 32'd1);
        tick();
        chk("first_resp", {30'b0, dmem_resp}, R_OK);
        chk("first_rdata", dmem_rdata, 32'h0);

        // Write word
        drive(1'b1, WR, W_W, BASE + 32'h10, 32'hDEADBEEF);
        chk("ww_wen", {31'b0, mem_wen}, 32'd1);
        chk("ww_ren", {31'b0, mem_ren}, 32'd0);
        chk("ww_web", {28'b0, mem_web}, 32'hF);
        chk("ww_addr", {16'b0, mem_addr}, 32'h10);
        chk("ww_wdata", mem_wdata, 32'hDEADBEEF);
        tick();

        // Write byte into lane 3
        drive(1'b1, WR, W_B, BASE + 32'h13, 32'h000000A5);
        chk("ww_resp", {30'b0, dmem_resp}, R_OK);
        chk("ww_rdata", dmem_rdata, 32'h0);
        chk("wb_web", {28'b0, mem_web}, 32'h8);
        chk("wb_wdata", mem_wdata, 32'hA5000000);
        chk("wb_addr", {16'b0, mem_addr}, 32'h13);
        tick();

        // Reads of the merged word
        drive(1'b1, RD, W_W, BASE + 32'h10, 32'hFFFFFFFF);
        chk("wb_resp", {30'b0, dmem_resp}, R_OK);
        chk("rw_ren", {31'b0, mem_ren}, 32'd1);
        chk("rw_wen", {31'b0, mem_wen}, 32'd0);
        tick();
        drive(1'b1, RD, W_H, BASE + 32'h12, 32'h0);
        chk("rw_resp", {30'b0, dmem_resp}, R_OK);
        chk("rw_rdata", dmem_rdata, 32'hA5ADBEEF);
        tick();
        drive(1'b1, RD, W_B, BASE + 32'h11, 32'h0);
        chk("rh_rdata", dmem_rdata, 32'h0000A5AD);
        tick();

        // Misaligned accesses
        drive(1'b1, RD, W_W, BASE + 32'h2, 32'h0);
        chk("rb_rdata", dmem_rdata, 32'h000000BE);
        no_strobe("mis_rw");
        tick();
        drive(1'b1, WR, W_H, BASE + 32'h1, 32'h1234);
        chk("mis_rw_resp", {30'b0, dmem_resp}, R_ERR);
        chk("mis_rw_rdata", dmem_rdata, 32'h0);
        no_strobe("mis_wh");
        tick();

        // Out of range and illegal width
        drive(1'b1, RD, W_W, BASE + SIZE, 32'h0);
        chk("mis_wh_resp", {30'b0, dmem_resp}, R_ERR);
        no_strobe("oor_top");
        tick();
        drive(1'b1, WR, W_W, BASE - 32'd4, 32'h55AA55AA);
        chk("oor_top_resp", {30'b0, dmem_resp}, R_ERR);
        chk("oor_top_rdata", dmem_rdata, 32'h0);
        no_strobe("oor_low");
        tick();
        drive(1'b1, RD, W_X, BASE, 32'h0);
        chk("oor_low_resp", {30'b0, dmem_resp}, R_ERR);
        no_strobe("w3");
        tick();

        // Idle with garbage on the other inputs
        drive(1'b0, WR, W_W, BASE + 32'h20, 32'hCAFEF00D);
        chk("w3_resp", {30'b0, dmem_resp}, R_ERR);
        no_strobe("idle");
        tick();

        // Streaming writes then streaming reads
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WR, W_W, BASE + 32'h20 + 32'(4*i), 32'h1000_0000 + 32'(i * 32'h111));
            chk("sw_resp", {30'b0, dmem_resp}, (i == 0) ? R_IDLE : R_OK);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, RD, W_W, BASE + 32'h20 + 32'(4*i), 32'h0);
            chk("sr_resp", {30'b0, dmem_resp}, R_OK);
            if (i > 0) chk("sr_rdata", dmem_rdata, 32'h1000_0000 + 32'((i-1) * 32'h111));
            tick();
        end
        drive(1'b0, RD, W_W, 32'h0, 32'h0);
        chk("sr_last_resp", {30'b0, dmem_resp}, R_OK);
        chk("sr_last_rdata", dmem_rdata, 32'h1000_0777);
        tick();
        chk("idle_resp", {30'b0, dmem_resp}, R_IDLE);

        // Reset in the middle of a pending read
        drive(1'b1, RD, W_W, BASE + 32'h10, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_resp", {30'b0, dmem_resp}, R_IDLE);
        chk("midrst_rdata", dmem_rdata, 32'h0);
        no_strobe("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
